// File: rtl/ama_riscv_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Request and response use valid/ready handshakes; kill aborts any in-flight or unconsumed result.
module ama_riscv_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q
);

  localparam int unsigned ARCH_WIDTH = 32;

  // op encoding follows funct3[1:0] of the M-extension divide group
  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  localparam logic [ARCH_WIDTH-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [ARCH_WIDTH-1:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [ARCH_WIDTH-1:0] ZERO     = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [ARCH_WIDTH-1:0] neg_f(input logic [ARCH_WIDTH-1:0] x);
    neg_f = (~x) + 32'd1;
  endfunction

  function automatic logic [ARCH_WIDTH-1:0] abs_f(input logic [ARCH_WIDTH-1:0] x);
    abs_f = x[ARCH_WIDTH-1] ? neg_f(x) : x;
  endfunction

  state_t                state_r;
  state_t                next_state_s;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [ARCH_WIDTH-1:0] q_r;

  logic [ARCH_WIDTH-1:0] rem_r;
  logic [ARCH_WIDTH-1:0] quo_r;
  logic [ARCH_WIDTH-1:0] div_r;
  logic [4:0]            cnt_r;
  logic                  qsign_r;
  logic                  rsign_r;
  logic [1:0]            op_r;

  logic                  accept_s;
  logic                  signed_op_s;
  logic                  rem_op_s;
  logic                  special_s;
  logic [ARCH_WIDTH-1:0] special_q_s;
  logic [ARCH_WIDTH:0]   shifted_s;
  logic [ARCH_WIDTH+1:0] diff_s;
  logic                  ge_s;
  logic [ARCH_WIDTH-1:0] fix_q_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign q         = q_r;

  // Request decode: acceptance, signedness and the short-circuit results
  always_comb begin
    accept_s    = in_valid && in_ready_r && !kill;
    signed_op_s = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    rem_op_s    = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    special_s   = 1'b0;
    special_q_s = ZERO;
    if (b == ZERO) begin
      special_s   = 1'b1;
      special_q_s = rem_op_s ? a : ALL_ONES;
    end else if (signed_op_s && (a == INT_MIN) && (b == ALL_ONES)) begin
      special_s   = 1'b1;
      special_q_s = rem_op_s ? ZERO : INT_MIN;
    end else begin
      special_s   = 1'b0;
      special_q_s = ZERO;
    end
  end

  // One restoring step; remainder stays below the divisor so the difference fits 32 bits
  always_comb begin
    shifted_s = {rem_r, quo_r[ARCH_WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, div_r};
    ge_s      = ~diff_s[ARCH_WIDTH+1];
  end

  // Sign correction and quotient/remainder selection for the FIX cycle
  always_comb begin
    if ((op_r == DIV_OP_REM) || (op_r == DIV_OP_REMU)) begin
      fix_q_s = rsign_r ? neg_f(rem_r) : rem_r;
    end else begin
      fix_q_s = qsign_r ? neg_f(quo_r) : quo_r;
    end
  end

  // Next-state logic; kill overrides everything except reset
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = special_s ? DONE : BUSY;
        end else begin
          next_state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 5'd0) begin
          next_state_s = FIX;
        end else begin
          next_state_s = BUSY;
        end
      end
      FIX:  next_state_s = DONE;
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
    if (kill) begin
      next_state_s = IDLE;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // State register and registered handshake/result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= ZERO;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      out_valid_r <= (next_state_s == DONE);
      if ((state_r == IDLE) && accept_s && special_s) begin
        q_r <= special_q_s;
      end else if ((state_r == FIX) && !kill) begin
        q_r <= fix_q_s;
      end else begin
        q_r <= q_r;
      end
    end
  end

  // Datapath: operand capture on acceptance, then one iteration per BUSY cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r   <= ZERO;
      quo_r   <= ZERO;
      div_r   <= ZERO;
      cnt_r   <= 5'd0;
      qsign_r <= 1'b0;
      rsign_r <= 1'b0;
      op_r    <= DIV_OP_DIV;
    end else if ((state_r == IDLE) && accept_s) begin
      op_r    <= op;
      rem_r   <= ZERO;
      quo_r   <= signed_op_s ? abs_f(a) : a;
      div_r   <= signed_op_s ? abs_f(b) : b;
      qsign_r <= signed_op_s && (a[ARCH_WIDTH-1] ^ b[ARCH_WIDTH-1]);
      rsign_r <= signed_op_s && a[ARCH_WIDTH-1];
      cnt_r   <= 5'd31;
    end else if (state_r == BUSY) begin
      rem_r <= ge_s ? diff_s[ARCH_WIDTH-1:0] : shifted_s[ARCH_WIDTH-1:0];
      quo_r <= {quo_r[ARCH_WIDTH-2:0], ge_s};
      cnt_r <= cnt_r - 5'd1;
    end else begin
      rem_r <= rem_r;
      quo_r <= quo_r;
      cnt_r <= cnt_r;
    end
  end

endmodule
